// File: rtl/lcm_gcd_host_if.sv
// lcm_gcd_host_if: bundles the upstream operand, GCD engine and downstream
// result handshakes of lcm_gcd_host.
// Ports (signals):
//   in_valid/in_ready/in_a/in_b
//   eng_req/eng_a/eng_b/eng_ack/eng_gcd
//   out_valid/out_ready/out_gcd/out_lcm/out_err
// Modports:
//   slave  - the host itself.
//   master - the surrounding environment.
//            It covers the operand source, the engine and the result sink.
interface lcm_gcd_host_if #(
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           eng_req;
    logic [W-1:0]   eng_a;
    logic [W-1:0]   eng_b;
    logic           eng_ack;
    logic [W-1:0]   eng_gcd;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_gcd;
    logic [2*W-1:0] out_lcm;
    logic           out_err;

    modport slave (
        input  in_valid, in_a, in_b, eng_ack, eng_gcd, out_ready,
        output in_ready, eng_req, eng_a, eng_b,
        output out_valid, out_gcd, out_lcm, out_err
    );

    modport master (
        output in_valid, in_a, in_b, eng_ack, eng_gcd, out_ready,
        input  in_ready, eng_req, eng_a, eng_b,
        input  out_valid, out_gcd, out_lcm, out_err
    );
endinterface

// File: rtl/lcm_gcd_host.sv
// lcm_gcd_host: asks an external engine for gcd(a,b).
// It then computes lcm = (a/gcd)*b with a restoring divider and a registered
// multiply, and returns gcd, lcm and an error flag downstream.
// Ports:
//   clk - rising-edge clock.
//   rst - asynchronous, active-high reset.
//   bus - lcm_gcd_host_if.slave.
//         It carries the in_*, eng_* and out_* handshakes.
// Macro HOST_TIMEOUT_EN:
//   When defined, it bounds the engine wait to TIMEOUT_CYCLES.
//   A timeout returns err=1.
module lcm_gcd_host #(
    parameter int W              = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    lcm_gcd_host_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_DIV, S_MUL, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   g_q, g_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   eng_a_q, eng_a_d;
    logic [W-1:0]   eng_b_q, eng_b_d;
    logic [W-1:0]   gcd_q, gcd_d;
    logic [2*W-1:0] lcm_q, lcm_d;
    logic           err_q, err_d;
    logic [W:0]     trial;
    logic [W-1:0]   mn;

`ifdef HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]  wcnt_q, wcnt_d;
`endif

    assign mn = (a_q < b_q) ? a_q : b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            eng_a_q <= '0;
            eng_b_q <= '0;
            gcd_q   <= '0;
            lcm_q   <= '0;
            err_q   <= 1'b0;
`ifdef HOST_TIMEOUT_EN
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            eng_a_q <= eng_a_d;
            eng_b_q <= eng_b_d;
            gcd_q   <= gcd_d;
            lcm_q   <= lcm_d;
            err_q   <= err_d;
`ifdef HOST_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        eng_a_d = eng_a_q;
        eng_b_d = eng_b_q;
        gcd_d   = gcd_q;
        lcm_d   = lcm_q;
        err_d   = err_q;
`ifdef HOST_TIMEOUT_EN
        wcnt_d  = wcnt_q;
`endif
        // Partial remainder shifted left by one, with the next dividend bit
        // brought in. It is the candidate for this step's subtraction.
        trial   = {rem_q, a_q[cnt_q]};
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d = bus.in_a;
                    b_d = bus.in_b;
                    if (bus.in_a == '0 || bus.in_b == '0) begin
                        gcd_d   = (bus.in_a > bus.in_b) ? bus.in_a : bus.in_b;
                        lcm_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                eng_a_d = a_q;
                eng_b_d = b_q;
`ifdef HOST_TIMEOUT_EN
                wcnt_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.eng_ack) begin
                    g_d = bus.eng_gcd;
                    // A usable gcd is nonzero and cannot exceed either operand.
                    if (bus.eng_gcd == '0 || bus.eng_gcd > mn) begin
                        gcd_d   = bus.eng_gcd;
                        lcm_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        quo_d   = '0;
                        rem_d   = '0;
                        cnt_d   = CNT_TOP;
                        state_d = S_DIV;
                    end
                end
`ifdef HOST_TIMEOUT_EN
                else if (wcnt_q == T_LAST) begin
                    gcd_d   = '0;
                    lcm_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            S_DIV: begin
                if (trial >= {1'b0, g_q}) begin
                    rem_d        = W'(trial - {1'b0, g_q});
                    quo_d[cnt_q] = 1'b1;
                end else begin
                    rem_d = trial[W-1:0];
                end
                if (cnt_q == '0) begin
                    state_d = S_MUL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MUL: begin
                gcd_d = g_q;
                // A leftover remainder means the engine's value does not divide a.
                if (rem_q != '0) begin
                    lcm_d = '0;
                    err_d = 1'b1;
                end else begin
                    lcm_d = (2*W)'(quo_q) * (2*W)'(b_q);
                    err_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.eng_req   = (state_q == S_WAIT);
    assign bus.eng_a     = eng_a_q;
    assign bus.eng_b     = eng_b_q;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_gcd   = gcd_q;
    assign bus.out_lcm   = lcm_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_lcm_gcd_host.sv
// tb_lcm_gcd_host: randomized and directed bench for lcm_gcd_host.
// It uses an engine responder, a queue-based scoreboard and an arithmetic model.
module tb_lcm_gcd_host;
    localparam int W   = 8;
    localparam int TO  = 16;
    localparam int LIM = 3000;

    typedef struct {
        logic [W-1:0]   g;
        logic [2*W-1:0] l;
        logic           e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;

    exp_t exp_q[$];
    bit   exp_eng = 0;
    int   exp_a = 0;
    int   exp_b = 0;
    bit   ack_en = 1;
    int   ack_val = 0;
    int   ack_dly = 1;
    int   ack_cyc = 0;
    int   req_cyc = 0;

    lcm_gcd_host_if #(.W(W)) bus ();

    lcm_gcd_host #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    function automatic int gcd_ref(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic exp_t model(input int a, input int b,
                                   input bit acked, input int r);
        exp_t e;
        int   mn;
        mn = (a < b) ? a : b;
        if (a == 0 || b == 0) begin
            e.g = W'((a > b) ? a : b); e.l = '0; e.e = 1'b0;
        end else if (!acked) begin
            e.g = '0; e.l = '0; e.e = 1'b1;
        end else if (r == 0 || r > mn || (a % r) != 0) begin
            e.g = W'(r); e.l = '0; e.e = 1'b1;
        end else begin
            e.g = W'(r); e.l = (2*W)'((a / r) * b); e.e = 1'b0;
        end
        return e;
    endfunction

    // Engine responder: checks operands, then acks after ack_dly cycles.
    initial begin
        bus.eng_ack = 1'b0;
        bus.eng_gcd = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.eng_req) begin
                int n;
                req_cyc = cyc;
                chk("eng_req_expected", 64'(bus.eng_req), 64'(exp_eng));
                chk("eng_a", 64'(bus.eng_a), 64'(exp_a));
                chk("eng_b", 64'(bus.eng_b), 64'(exp_b));
                if (ack_en) begin
                    repeat (ack_dly) @(negedge clk);
                    bus.eng_ack = 1'b1;
                    bus.eng_gcd = W'(ack_val);
                    ack_cyc = cyc;
                    @(negedge clk);
                    bus.eng_ack = 1'b0;
                    chk("eng_req_drop", 64'(bus.eng_req), 64'd0);
                end
                n = 0;
                while (bus.eng_req && n < LIM) begin
                    @(negedge clk);
                    n++;
                end
                chk("eng_req_release", 64'(bus.eng_req), 64'd0);
            end
        end
    end

    // Scoreboard monitor: compares each accepted result with the queue head.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_gcd", 64'(bus.out_gcd), 64'(e.g));
                chk("out_lcm", 64'(bus.out_lcm), 64'(e.l));
                chk("out_err", 64'(bus.out_err), 64'(e.e));
            end
        end
    end

    task automatic run(input int a, input int b, input bit acked,
                       input int r, input int dly);
        exp_t e;
        int   n;
        int   acc;
        bit   eng;
        eng = (a != 0 && b != 0);
        e = model(a, b, acked, r);
        exp_eng = eng;
        exp_a = a;
        exp_b = b;
        ack_en = acked;
        ack_val = r;
        ack_dly = dly;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_a = W'(a);
        bus.in_b = W'(b);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_wait", 64'(bus.out_valid), 64'd1);
        if (!eng) chk("lat_zero", 64'(cyc - acc), 64'd1);
        else if (!acked) chk("lat_timeout", 64'(cyc - req_cyc), 64'(TO));
        else if (!e.e) chk("lat_norm", 64'(cyc - ack_cyc), 64'(W + 2));
        if (bus.out_ready) begin
            n = 0;
            while (!bus.in_ready && n < LIM) begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        int r;
        int n;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_eng_req", 64'(bus.eng_req), 64'd0);
        chk("rst_eng_a", 64'(bus.eng_a), 64'd0);
        chk("rst_eng_b", 64'(bus.eng_b), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_gcd", 64'(bus.out_gcd), 64'd0);
        chk("rst_out_lcm", 64'(bus.out_lcm), 64'd0);
        chk("rst_out_err", 64'(bus.out_err), 64'd0);
        rst = 1'b0;

        run(12, 18, 1, 6, 3);
        run(0, 5, 1, 0, 1);
        run(255, 254, 1, 1, 2);
        run(12, 18, 1, 5, 2);
        run(12, 18, 1, 0, 1);
        run(7, 3, 1, 9, 1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) r = gcd_ref(a, b);
            else r = $urandom_range(0, 255);
            run(a, b, 1, r, $urandom_range(1, 6));
        end

        bus.out_ready = 1'b0;
        run(20, 30, 1, 10, 2);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_gcd", 64'(bus.out_gcd), 64'd10);
            chk("bp_out_lcm", 64'(bus.out_lcm), 64'd60);
            chk("bp_out_err", 64'(bus.out_err), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
        chk("bp_valid_drop", 64'(bus.out_valid), 64'd0);
        chk("bp_gcd_kept", 64'(bus.out_gcd), 64'd10);

        exp_eng = 1;
        exp_a = 12;
        exp_b = 18;
        ack_en = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_a = 8'd12;
        bus.in_b = 8'd18;
        @(negedge clk);
        chk("rr_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.eng_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rr_eng_req_high", 64'(bus.eng_req), 64'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rr_eng_req_low", 64'(bus.eng_req), 64'd0);
        chk("rr_in_ready_high", 64'(bus.in_ready), 64'd1);
        chk("rr_out_valid_low", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ack_en = 1;
        repeat (3) @(negedge clk);

`ifdef HOST_TIMEOUT_EN
        run(12, 18, 0, 0, 1);
`endif
        run(24, 36, 1, 12, 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/lcm_gcd_host.md
Name: lcm_gcd_host

Overview:
- Initiator side of the GCD engine interface.
- Accepts an operand pair from upstream over a valid/ready handshake. Requests the GCD from an external subtraction-based GCD engine over a req/ack handshake.
- Computes LCM = (a / gcd) * b using an internal sequential restoring divider and a registered multiply.
- Returns gcd, lcm and an error flag downstream. Sits between the operand source and the GCD engine in the number-theory datapath.

Parameters:
- W, 8, operand and gcd width in bits; lcm is 2*W bits.
- TIMEOUT_CYCLES, 1024, maximum engine wait cycles. Used only with HOST_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  host can accept a pair (high only in IDLE).
- in_a  input  W  operand a.
- in_b  input  W  operand b.
- eng_req  output  1  request to GCD engine.
- eng_a  output  W  operand a to engine; stable while eng_req high.
- eng_b  output  W  operand b to engine; stable while eng_req high.
- eng_ack  input  1  engine result valid, one-cycle pulse.
- eng_gcd  input  W  engine result, sampled when eng_ack is high.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_gcd  output  W  gcd result.
- out_lcm  output  2W  lcm result.
- out_err  output  1  error flag for this result.

Behaviour:
- Reset (async, any state): state=IDLE.
  - in_ready=1, eng_req=0, eng_a=0, eng_b=0.
  - out_valid=0, out_gcd=0, out_lcm=0, out_err=0.
  - Internal a/b/quotient/remainder/counter regs = 0.
- IDLE: in_ready=1. On in_valid, capture a, b.
  - If a==0 or b==0: go to DONE with gcd=max(a,b), lcm=0, err=0. No engine request.
  - Else: go to REQ.
- REQ: drive eng_a/eng_b from captured regs, assert eng_req, go to WAIT.
- WAIT: eng_req stays high. On eng_ack, latch gcd=eng_gcd and deassert eng_req the next cycle.
  - If eng_gcd==0 or eng_gcd > min(a,b): err=1, lcm=0, go to DONE.
  - Else: go to DIV.
  - eng_ack outside WAIT is ignored.
- DIV: restoring division a/gcd, one quotient bit per cycle, MSB first.
  - Exactly W cycles; counter counts W-1 down to 0.
  - Remainder must end at 0; a nonzero remainder sets err=1 and lcm=0.
- MUL: lcm = quotient * b as a full 2W-bit product, no truncation. Registered in 1 cycle. Go to DONE.
- DONE: out_valid=1, outputs held stable until out_ready.
  - On out_valid && out_ready: go to IDLE next cycle. out_* keep their values; only out_valid drops.
- Latency:
  - Zero-operand case: in accept -> out_valid at +1 cycle.
  - Normal case: eng_ack cycle -> out_valid at +W+2 cycles.
- in_ready is low in every state except IDLE. There is no pipelining: one pair is in flight at a time.
- Max lcm for W=8: 255*254 = 64770, which fits in 16 bits.

Optional Feature:
- Macro: HOST_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES without eng_ack: deassert eng_req, set err=1, gcd=0, lcm=0, go to DONE.
  - An eng_ack arriving in the same cycle as the timeout wins; normal processing continues.
- Not defined: WAIT waits indefinitely for eng_ack. No counter logic is instantiated.

Test Plan:
- in_a=12, in_b=18; engine acks 6 three cycles after eng_req -> out_gcd=6, out_lcm=36, out_err=0. out_valid rises W+2=10 cycles after the ack.
- in_a=0, in_b=5 -> eng_req never asserted; out_gcd=5, out_lcm=0, out_err=0. out_valid 1 cycle after accept.
- in_a=255, in_b=254; engine acks 1 -> out_lcm=64770, out_gcd=1, out_err=0.
- in_a=12, in_b=18; engine acks 5 (bad divisor) -> out_err=1, out_lcm=0. Separately, an ack of 0 -> out_err=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_* stable and in_ready=0 throughout. With out_ready=1, in_ready returns to 1 the cycle after.
- Reset asserted mid-WAIT with eng_req=1 -> eng_req=0 and in_ready=1 immediately, asynchronously. With HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16 and no ack -> out_err=1 after 16 WAIT cycles.
